// File: rtl/seq_mul_ctrl.sv
// Sequential shift-and-add unsigned multiplier: one add-and-shift per clock,
// with a start/done handshake and a held product register.
module seq_mul_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mplr;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] next_am;
    logic               accept;

    // The adder carry becomes the top bit of acc after the right shift.
    always_comb begin
        sum     = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : '0);
        next_am = {sum, mplr[WIDTH-1:1]};
        accept  = start && ((state == IDLE) || (state == DONE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            mplr    <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                CALC: begin
                    {acc, mplr} <= next_am;
                    cnt         <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        product <= next_am;
                        state   <= DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        mcand <= a;
                        mplr  <= b;
                        acc   <= '0;
                        cnt   <= CW'(WIDTH);
                        state <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Self-checking bench for seq_mul_ctrl: directed corner cases plus random
// operands compared against plain multiplication.
module tb_seq_mul_ctrl;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] last = '0;

    seq_mul_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Waits for done (bounded); edges is the accept-relative edge index, -1 on timeout.
    task automatic wait_done(output int edges, output int busyc, output bit held,
                             input logic [2*W-1:0] hold, input bit probe);
        bit seen = 0;
        edges = -1;
        busyc = 0;
        held  = 1;
        for (int n = 0; n < 4 * int'(W) && !seen; n++) begin
            @(negedge clk);
            if (probe && n == 2) begin
                start = 1'b1;
                a     = W'(9);
                b     = W'(9);
            end
            if (probe && n == 3) start = 1'b0;
            if (done) begin
                seen  = 1;
                edges = n;
            end else begin
                if (busy) busyc++;
                if (product !== hold) held = 0;
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit probe);
        int e, bc;
        bit h;
        logic [2*W-1:0] exp;
        exp   = (2*W)'(x) * (2*W)'(y);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        wait_done(e, bc, h, last, probe);
        check("latency", 64'(e), 64'(W));
        check("busy_cycles", 64'(bc), 64'(W));
        check("product_hold", 64'(h), 64'd1);
        check("product", 64'(product), 64'(exp));
        last = exp;
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
    endtask

    task automatic idle_nodone(input int cycles, input string tag);
        int cnt_done = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) cnt_done++;
        end
        check(tag, 64'(cnt_done), 64'd0);
    endtask

    initial begin
        int e, bc;
        bit h;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_nodone(20, "idle_no_done");

        run_op(W'(13), W'(11), 1'b0);

        // Asynchronous reset mid-cycle with a non-zero product held.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_product", 64'(product), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last  = '0;

        run_op(W'(255), W'(255), 1'b0);
        run_op(W'(0), W'(200), 1'b0);
        run_op(W'(1), W'(1), 1'b0);

        run_op(W'(6), W'(7), 1'b1);
        idle_nodone(2 * int'(W), "ignored_start");

        // Back-to-back with start held high.
        a     = W'(3);
        b     = W'(5);
        start = 1'b1;
        @(posedge clk);
        #1;
        a = W'(10);
        b = W'(20);
        wait_done(e, bc, h, last, 1'b0);
        check("b2b_first_edge", 64'(e), 64'(W));
        check("b2b_first_product", 64'(product), 64'd15);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        wait_done(e, bc, h, 16'd15, 1'b0);
        check("b2b_second_edge", 64'(e + int'(W) + 1), 64'(2 * W + 1));
        check("b2b_hold_15", 64'(h), 64'd1);
        check("b2b_second_product", 64'(product), 64'd200);
        last = 16'd200;
        @(negedge clk);

        // Reset in the middle of an operation.
        a     = W'(100);
        b     = W'(100);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midop_rst_busy", 64'(busy), 64'd0);
        check("midop_rst_product", 64'(product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last  = '0;
        idle_nodone(20, "midop_no_done");
        run_op(W'(2), W'(3), 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
